// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes
// and writable-bit masks for the exception controller.
package cp0_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_BP  = 5'd9;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   // Status: IM[15:8], EXL[1], IE[0]; Cause: IP1..0 only
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky timer-interrupt flag.
// Ports: clk, rst, count_we/compare_we + wdata in; count, compare, ti out.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic [31:0] count_nx;

   // an mtc0 to Count replaces this cycle's increment
   assign count_nx = count_we ? wdata : count + 32'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         count <= count_nx;
         if (compare_we)
            compare <= wdata;
         // clearing via Compare write beats a same-cycle match
         if (compare_we)
            ti <= 1'b0;
         else if (count_nx == compare)
            ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: arbitrates exceptions/interrupts/eret,
// holds Status/Cause/EPC, drives a registered flush + redirect PC.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int          HW_INT_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instValid,
   input  logic [31:0]         pcIn,
   input  logic                inDelaySlot,
   input  logic                aluException,
   input  logic                syscallExc,
   input  logic                breakExc,
   input  logic                riExc,
   input  logic                eret,
   input  logic [HW_INT_W-1:0] hwInt,
   input  logic                cp0We,
   input  logic [4:0]          cp0Addr,
   input  logic [31:0]         cp0Wdata,
   output logic [31:0]         cp0Rdata,
   output logic                flush,
   output logic [31:0]         excTarget,
   output logic [31:0]         epcOut
);

   logic [31:0] status;
   logic [31:0] epc;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   logic        bd;
   logic [4:0]  exc_code;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   logic        int_pending;
   logic        exc_take;
   logic        eret_take;
   logic        mtc0_take;
   logic [4:0]  code_nx;
   logic [7:0]  ip;

   assign ip          = {ip_hw, ip_sw};
   assign int_pending = status[0] & ~status[1]
                      & |(ip & status[15:8]);

   always_comb begin
      exc_take = 1'b0;
      code_nx  = EXC_INT;
      if (instValid) begin
         priority case (1'b1)
            int_pending:  begin exc_take = 1'b1; code_nx = EXC_INT; end
            riExc:        begin exc_take = 1'b1; code_nx = EXC_RI;  end
            syscallExc:   begin exc_take = 1'b1; code_nx = EXC_SYS; end
            breakExc:     begin exc_take = 1'b1; code_nx = EXC_BP;  end
            aluException: begin exc_take = 1'b1; code_nx = EXC_OV;  end
            default:      exc_take = 1'b0;
         endcase
      end
   end

   assign eret_take = instValid & eret & ~exc_take;
   assign mtc0_take = instValid & cp0We & ~exc_take & ~eret_take;

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_take && cp0Addr == CP0_COUNT),
      .compare_we (mtc0_take && cp0Addr == CP0_COMPARE),
      .wdata      (cp0Wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         status    <= '0;
         epc       <= '0;
         ip_hw     <= '0;
         ip_sw     <= '0;
         bd        <= 1'b0;
         exc_code  <= '0;
         flush     <= 1'b0;
         excTarget <= '0;
      end else begin
         // IP7 carries the timer interrupt alongside hwInt[5]
         ip_hw     <= {hwInt[5] | ti, hwInt[4:0]};
         flush     <= exc_take | eret_take;
         excTarget <= exc_take  ? EXC_VECTOR :
                      eret_take ? epc : '0;
         if (exc_take) begin
            exc_code  <= code_nx;
            status[1] <= 1'b1;
            // nested exceptions keep the original return point
            if (!status[1]) begin
               epc <= inDelaySlot ? pcIn - 32'd4 : pcIn;
               bd  <= inDelaySlot;
            end
         end else if (eret_take) begin
            status[1] <= 1'b0;
         end else if (mtc0_take) begin
            case (cp0Addr)
               CP0_STATUS: status <= cp0Wdata & STATUS_WMASK;
               CP0_CAUSE:  ip_sw  <= cp0Wdata[9:8];
               CP0_EPC:    epc    <= cp0Wdata;
               default:    ;
            endcase
         end
      end
   end

   always_comb begin
      cp0Rdata = '0;
      case (cp0Addr)
         CP0_COUNT:   cp0Rdata = count;
         CP0_COMPARE: cp0Rdata = compare;
         CP0_STATUS:  cp0Rdata = status;
         CP0_CAUSE:   cp0Rdata = {bd, ti, 14'd0, ip_hw, ip_sw,
                                  1'b0, exc_code, 2'b00};
         CP0_EPC:     cp0Rdata = epc;
         default:     cp0Rdata = '0;
      endcase
   end

   assign epcOut = epc;

endmodule
